// File: rtl/regfile_sb.sv
// Purpose: register file plus per-register reservation scoreboard for the in-order pipeline.
// Latency: reads, hazard and debug outputs are combinational; writes/reservations land on the next clk edge.
// Backpressure: none; write-back is accepted every cycle, decode stalls itself on reserved_o.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset (clears regs and busy bits)
//   r0_num_i / r0_data_o     read port 0 (rd, also the reservation target), write-back bypassed
//   r1_num_i / r1_data_o     read port 1 (rs), write-back bypassed
//   w_reserve_i              reserve r0_num_i as a destination, taken only when no hazard and no flush
//   reserved_o               hazard: r0 or r1 still waits for a write-back
//   wb_v_i/wb_num_i/wb_data_i write-back: writes data and releases the reservation
//   flush_i                  clears every reservation (write-back in the same cycle still writes)
//   dbg_num_i / dbg_data_o / dbg_busy_o  raw, unbypassed debug view
module regfile_sb #(
    parameter int WORD  = 32,
    parameter int W_RD  = 4,
    parameter int W_RS  = 4,
    parameter int N_REG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W_RD-1:0] r0_num_i,
    input  logic [W_RS-1:0] r1_num_i,
    output logic [WORD-1:0] r0_data_o,
    output logic [WORD-1:0] r1_data_o,
    input  logic            w_reserve_i,
    output logic            reserved_o,
    input  logic            wb_v_i,
    input  logic [W_RD-1:0] wb_num_i,
    input  logic [WORD-1:0] wb_data_i,
    input  logic            flush_i,
    input  logic [W_RD-1:0] dbg_num_i,
    output logic [WORD-1:0] dbg_data_o,
    output logic            dbg_busy_o
);

    logic [WORD-1:0]  regs_q [N_REG];
    logic [WORD-1:0]  regs_d [N_REG];
    logic [N_REG-1:0] busy_q;
    logic [N_REG-1:0] busy_d;

    logic wb_hit0;
    logic wb_hit1;
    logic res_ok;

    // A write-back aimed at a read register both supplies the data and
    // cancels that register's hazard in the same cycle.
    assign wb_hit0 = wb_v_i && (wb_num_i == r0_num_i);
    assign wb_hit1 = wb_v_i && (wb_num_i == r1_num_i);

    assign r0_data_o = wb_hit0 ? wb_data_i : regs_q[r0_num_i];
    assign r1_data_o = wb_hit1 ? wb_data_i : regs_q[r1_num_i];

    // rd is checked too: a pending write to the destination must retire
    // before a new owner may claim it.
    assign reserved_o = (busy_q[r0_num_i] && !wb_hit0) ||
                        (busy_q[r1_num_i] && !wb_hit1);

    assign res_ok = w_reserve_i && !reserved_o && !flush_i;

    assign dbg_data_o = regs_q[dbg_num_i];
    assign dbg_busy_o = busy_q[dbg_num_i];

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wb_v_i) begin
            regs_d[wb_num_i] = wb_data_i;
            busy_d[wb_num_i] = 1'b0;
        end
        // Ordering matters: a reserve on the register being written back
        // makes the issuing instruction the new owner, so it is applied last.
        if (flush_i) begin
            busy_d = '0;
        end else if (res_ok) begin
            busy_d[r0_num_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  r0_num_i;
    logic [3:0]  r1_num_i;
    logic [31:0] r0_data_o;
    logic [31:0] r1_data_o;
    logic        w_reserve_i;
    logic        reserved_o;
    logic        wb_v_i;
    logic [3:0]  wb_num_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic [3:0]  dbg_num_i;
    logic [31:0] dbg_data_o;
    logic        dbg_busy_o;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural register values and outstanding reservations.
    logic [31:0] m_regs [16];
    bit          m_busy [16];

    always #5 clk = ~clk;

    regfile_sb #(.WORD(32), .W_RD(4), .W_RS(4), .N_REG(16)) dut (
        .clk(clk), .rst(rst),
        .r0_num_i(r0_num_i), .r1_num_i(r1_num_i),
        .r0_data_o(r0_data_o), .r1_data_o(r1_data_o),
        .w_reserve_i(w_reserve_i), .reserved_o(reserved_o),
        .wb_v_i(wb_v_i), .wb_num_i(wb_num_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .dbg_num_i(dbg_num_i), .dbg_data_o(dbg_data_o), .dbg_busy_o(dbg_busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Operand is pending unless the write-back retiring it arrives this cycle.
    function automatic bit pending(input logic [3:0] n);
        return m_busy[n] && !(wb_v_i && wb_num_i == n);
    endfunction

    function automatic logic [31:0] read_val(input logic [3:0] n);
        return (wb_v_i && wb_num_i == n) ? wb_data_i : m_regs[n];
    endfunction

    // Drive one cycle's inputs after the falling edge and check all outputs.
    task automatic apply(input logic [3:0] r0, input logic [3:0] r1, input logic res,
                         input logic wbv, input logic [3:0] wbn, input logic [31:0] wbd,
                         input logic fl, input logic [3:0] dn);
        @(negedge clk);
        r0_num_i = r0; r1_num_i = r1; w_reserve_i = res;
        wb_v_i = wbv; wb_num_i = wbn; wb_data_i = wbd;
        flush_i = fl; dbg_num_i = dn;
        #1;
        chk("r0_data", r0_data_o, read_val(r0));
        chk("r1_data", r1_data_o, read_val(r1));
        chk("reserved", {31'b0, reserved_o}, {31'b0, pending(r0) | pending(r1)});
        chk("dbg_data", dbg_data_o, m_regs[dn]);
        chk("dbg_busy", {31'b0, dbg_busy_o}, {31'b0, m_busy[dn]});
    endtask

    // Commit the cycle in the model at the rising edge.
    task automatic tick();
        bit hazard;
        @(posedge clk);
        hazard = pending(r0_num_i) | pending(r1_num_i);
        if (wb_v_i) begin
            m_regs[wb_num_i] = wb_data_i;
            m_busy[wb_num_i] = 1'b0;
        end
        if (flush_i) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        end else if (w_reserve_i && !hazard) begin
            m_busy[r0_num_i] = 1'b1;
        end
    endtask

    task automatic idle(input logic [3:0] dn);
        apply(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, dn);
    endtask

    initial begin
        rst = 1'b0;
        r0_num_i = '0; r1_num_i = '0; w_reserve_i = 1'b0;
        wb_v_i = 1'b0; wb_num_i = '0; wb_data_i = '0;
        flush_i = 1'b0; dbg_num_i = '0;
        model_clear();

        // Reset state
        @(negedge clk);
        r0_num_i = 4'd3; r1_num_i = 4'd5; dbg_num_i = 4'd3;
        #1;
        chk("rst_r0", r0_data_o, 32'h0);
        chk("rst_r1", r1_data_o, 32'h0);
        chk("rst_reserved", {31'b0, reserved_o}, 32'h0);
        chk("rst_dbg_busy", {31'b0, dbg_busy_o}, 32'h0);
        rst = 1'b1;

        // Plain read and write-back
        apply(4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3);
        chk("read_zero", r0_data_o, 32'h0);
        tick();
        apply(4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 32'h1234, 1'b0, 4'd3); tick();
        apply(4'd3, 4'd5, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3);
        chk("wb_r3", r0_data_o, 32'h1234);
        tick();

        // Reserve r4, hazard on rs, repeated reserve ignored
        apply(4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd4); tick();
        apply(4'd0, 4'd4, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd4);
        chk("busy4_set", {31'b0, dbg_busy_o}, 32'h1);
        chk("hazard_r4", {31'b0, reserved_o}, 32'h1);
        tick();
        apply(4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd4); tick();

        // Hazard released by same-cycle write-back bypass
        apply(4'd0, 4'd4, 1'b0, 1'b1, 4'd4, 32'hBEEF, 1'b0, 4'd4);
        chk("bypass_hazard", {31'b0, reserved_o}, 32'h0);
        chk("bypass_data", r1_data_o, 32'hBEEF);
        tick();
        idle(4'd4);
        chk("busy4_clr", {31'b0, dbg_busy_o}, 32'h0);
        tick();

        // Write-back and reserve of r7 in the same cycle: reserve wins
        apply(4'd7, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd7); tick();
        apply(4'd7, 4'd0, 1'b1, 1'b1, 4'd7, 32'h7777, 1'b0, 4'd7);
        chk("wb_res_hazard", {31'b0, reserved_o}, 32'h0);
        tick();
        idle(4'd7);
        chk("r7_data", dbg_data_o, 32'h7777);
        chk("r7_busy", {31'b0, dbg_busy_o}, 32'h1);
        tick();

        // Flush beats reserve, write-back still commits
        apply(4'd1, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd1); tick();
        apply(4'd2, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd2); tick();
        apply(4'd9, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd9); tick();
        apply(4'd10, 4'd0, 1'b1, 1'b1, 4'd2, 32'h55, 1'b1, 4'd10); tick();
        for (int n = 0; n < 16; n++) begin
            idle(4'(n));
            chk("flush_busy", {31'b0, dbg_busy_o}, 32'h0);
            tick();
        end
        idle(4'd2);
        chk("flush_wb", dbg_data_o, 32'h55);
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
            tick();
        end

        // Mid-operation asynchronous reset
        apply(4'd3, 4'd0, 1'b1, 1'b1, 4'd5, 32'hA5A5_0001, 1'b1, 4'd3); tick();
        apply(4'd3, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3); tick();
        idle(4'd5);
        chk("pre_rst_data", dbg_data_o, 32'hA5A5_0001);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            dbg_num_i = 4'(n);
            #1;
            chk("arst_busy", {31'b0, dbg_busy_o}, 32'h0);
            chk("arst_data", dbg_data_o, 32'h0);
        end
        model_clear();
        rst = 1'b1;
        for (int k = 0; k < 40; k++) begin
            apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), $urandom, 1'b0, 4'($urandom_range(0, 15)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
